// File: rtl/sync_edge_pkg.sv
// Shared constants for the multi-channel edge-filtering synchroniser.
// Edge-mode encodings, default parameters and the edge-select helper.
package sync_edge_pkg;

  localparam logic [1:0] EDGE_OFF  = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  localparam int DEF_CHANNELS      = 4;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_FILTER_CYCLES = 4;
  localparam int DEF_CNT_WIDTH     = 8;

  // rising=1 for a 0->1 level change, 0 for 1->0
  function automatic logic edge_hit(
    input logic [1:0] mode,
    input logic       rising
  );
    logic hit;
    hit = 1'b0;
    unique case (mode)
      EDGE_OFF:  hit = 1'b0;
      EDGE_RISE: hit = rising;
      EDGE_FALL: hit = ~rising;
      EDGE_BOTH: hit = 1'b1;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/sync_edge_filter_if.sv
// Bundle of per-channel inputs and filtered outputs.
// master: drives in/edge_mode/clear; slave: drives level/pulse/status/any_pulse.
interface sync_edge_filter_if
  import sync_edge_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS
);

  logic [CHANNELS-1:0]   in;
  logic [2*CHANNELS-1:0] edge_mode;
  logic [CHANNELS-1:0]   clear;
  logic [CHANNELS-1:0]   level;
  logic [CHANNELS-1:0]   pulse;
  logic [CHANNELS-1:0]   status;
  logic                  any_pulse;

  modport master (
    output in, edge_mode, clear,
    input  level, pulse, status, any_pulse
  );

  modport slave (
    input  in, edge_mode, clear,
    output level, pulse, status, any_pulse
  );

endinterface

// File: rtl/sync_edge_ch.sv
// One channel: bit synchroniser, stability filter, edge pulse, sticky flag.
// Ports: clk, reset_n, in, edge_mode[1:0], clear -> level, pulse, status.
module sync_edge_ch
  import sync_edge_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int FILTER_CYCLES = DEF_FILTER_CYCLES,
  parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in,
  input  logic [1:0] edge_mode,
  input  logic       clear,
  output logic       level,
  output logic       pulse,
  output logic       status
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    CNT_WIDTH'(FILTER_CYCLES - 1);

  (* ASYNC_REG = "TRUE" *)
  logic [SYNC_STAGES-1:0] s;
  logic [CNT_WIDTH-1:0]   cnt;
  logic                   sync_out;

  assign sync_out = s[SYNC_STAGES-1];

  // s[0] is the metastability capture flop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s <= '0;
    end else begin
      s <= {s[SYNC_STAGES-2:0], in};
    end
  end

  // level moves only after FILTER_CYCLES consecutive deviating samples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (sync_out == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync_out;
        pulse <= edge_hit(edge_mode, sync_out);
      end else begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
    end
  end

  // set beats clear so a colliding event is never lost
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status <= 1'b0;
    end else if (pulse) begin
      status <= 1'b1;
    end else if (clear) begin
      status <= 1'b0;
    end
  end

endmodule

// File: rtl/sync_edge_filter.sv
// Multi-channel synchroniser with glitch filter and edge events.
// Ports: clk, reset_n, bus (slave: in/edge_mode/clear -> level/pulse/status/any_pulse).
module sync_edge_filter
  import sync_edge_pkg::*;
#(
  parameter int CHANNELS      = DEF_CHANNELS,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int FILTER_CYCLES = DEF_FILTER_CYCLES,
  parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
  input logic              clk,
  input logic              reset_n,
  sync_edge_filter_if.slave bus
);

  logic [CHANNELS-1:0] level_w;
  logic [CHANNELS-1:0] pulse_w;
  logic [CHANNELS-1:0] status_w;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    sync_edge_ch #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .CNT_WIDTH    (CNT_WIDTH)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .in       (bus.in[i]),
      .edge_mode(bus.edge_mode[2*i+1:2*i]),
      .clear    (bus.clear[i]),
      .level    (level_w[i]),
      .pulse    (pulse_w[i]),
      .status   (status_w[i])
    );
  end

  assign bus.level  = level_w;
  assign bus.pulse  = pulse_w;
  assign bus.status = status_w;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.any_pulse <= 1'b0;
    end else begin
      bus.any_pulse <= |pulse_w;
    end
  end

endmodule

// File: tb/tb_sync_edge_filter.sv
// Bench for sync_edge_filter: two configurations against a sample-history model.
// Instance A: SYNC_STAGES=2 FILTER_CYCLES=4; instance B: SYNC_STAGES=3 FILTER_CYCLES=1.
module tb_sync_edge_filter;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  sync_edge_filter_if #(.CHANNELS(4)) bus_a ();
  sync_edge_filter_if #(.CHANNELS(4)) bus_b ();

  sync_edge_filter #(
    .CHANNELS(4), .SYNC_STAGES(2),
    .FILTER_CYCLES(4), .CNT_WIDTH(8)
  ) u_dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a)
  );

  sync_edge_filter #(
    .CHANNELS(4), .SYNC_STAGES(3),
    .FILTER_CYCLES(1), .CNT_WIDTH(8)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // hist[u][c][0] is the input sampled on the latest edge.
  // The synchronised value seen before edge k is the input
  // sampled SS edges earlier; level flips once the last FC
  // of those all differ from it.
  logic [15:0] hist [2][4];
  logic [3:0]  m_level  [2];
  logic [3:0]  m_pulse  [2];
  logic [3:0]  m_status [2];
  logic        m_any    [2];
  logic [3:0]  t_in, t_clr, t_nl, t_np;
  logic [7:0]  t_md;
  logic        t_dev;

  function automatic int ss_of(input int u);
    return (u == 0) ? 2 : 3;
  endfunction

  function automatic int fc_of(input int u);
    return (u == 0) ? 4 : 1;
  endfunction

  // mode bit0 selects rising, bit1 selects falling
  function automatic logic sel(input logic [1:0] m, input logic r);
    return r ? m[0] : m[1];
  endfunction

  task automatic model_reset;
    for (int u = 0; u < 2; u++) begin
      for (int c = 0; c < 4; c++) hist[u][c] = '0;
      m_level[u]  = '0;
      m_pulse[u]  = '0;
      m_status[u] = '0;
      m_any[u]    = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        model_reset();
      end else begin
        for (int u = 0; u < 2; u++) begin
          t_in  = (u == 0) ? bus_a.in        : bus_b.in;
          t_md  = (u == 0) ? bus_a.edge_mode : bus_b.edge_mode;
          t_clr = (u == 0) ? bus_a.clear     : bus_b.clear;
          t_nl  = m_level[u];
          t_np  = '0;
          for (int c = 0; c < 4; c++) begin
            t_dev = 1'b1;
            for (int j = ss_of(u) - 1;
                 j <= ss_of(u) + fc_of(u) - 2; j++)
              if (hist[u][c][j] == m_level[u][c]) t_dev = 1'b0;
            if (t_dev) begin
              t_nl[c] = ~m_level[u][c];
              t_np[c] = sel(t_md[2*c+:2], t_nl[c]);
            end
            hist[u][c] = {hist[u][c][14:0], t_in[c]};
          end
          m_any[u]    = |m_pulse[u];
          m_status[u] = m_pulse[u] | (m_status[u] & ~t_clr);
          m_pulse[u]  = t_np;
          m_level[u]  = t_nl;
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset;
    logic [3:0] el, ep, es;
    logic       ea;
    reset_n = 1'b0;
    bus_a.in = 4'hF;
    bus_a.edge_mode = 8'h55;
    bus_a.clear = '0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if ({bus_a.level, bus_a.pulse, bus_a.status,
           bus_a.any_pulse} !== 13'h0) begin
        errors++;
        $display("FAIL reset_hold got l=%h p=%h s=%h a=%b want 0",
                 bus_a.level, bus_a.pulse, bus_a.status,
                 bus_a.any_pulse);
      end
    end
    reset_n = 1'b1;
    for (int t = 1; t <= 9; t++) begin
      @(negedge clk);
      el = (t >= 6) ? 4'hF : 4'h0;
      ep = (t == 6) ? 4'hF : 4'h0;
      es = (t >= 7) ? 4'hF : 4'h0;
      ea = (t == 7);
      checks++;
      if ({bus_a.level, bus_a.pulse, bus_a.status,
           bus_a.any_pulse} !== {el, ep, es, ea}) begin
        errors++;
        $display("FAIL reset_release e%0d got l=%h p=%h s=%h a=%b want l=%h p=%h s=%h a=%b",
                 t, bus_a.level, bus_a.pulse, bus_a.status,
                 bus_a.any_pulse, el, ep, es, ea);
      end
    end
  endtask

  task automatic test_glitch;
    logic el, ep;
    bus_a.in = 4'h0;
    bus_a.edge_mode = 8'h03;
    repeat (8) @(negedge clk);
    bus_a.clear = 4'hF;
    @(negedge clk);
    bus_a.clear = 4'h0;
    for (int t = 1; t <= 12; t++) begin
      bus_a.in[0] = (t <= 3);
      @(negedge clk);
      checks++;
      if (bus_a.level[0] !== 1'b0 || bus_a.pulse[0] !== 1'b0) begin
        errors++;
        $display("FAIL glitch3 e%0d got l=%b p=%b want 0 0",
                 t, bus_a.level[0], bus_a.pulse[0]);
      end
    end
    for (int t = 1; t <= 14; t++) begin
      bus_a.in[0] = (t <= 4);
      @(negedge clk);
      el = (t >= 6 && t < 10);
      ep = (t == 6 || t == 10);
      checks++;
      if ({bus_a.level[0], bus_a.pulse[0]} !== {el, ep}) begin
        errors++;
        $display("FAIL glitch4 e%0d got l=%b p=%b want l=%b p=%b",
                 t, bus_a.level[0], bus_a.pulse[0], el, ep);
      end
      checks++;
      if ({bus_a.level, bus_a.pulse, bus_a.status,
           bus_a.any_pulse} !==
          {m_level[0], m_pulse[0], m_status[0], m_any[0]}) begin
        errors++;
        $display("FAIL glitch_model e%0d got l=%h p=%h s=%h want l=%h p=%h s=%h",
                 t, bus_a.level, bus_a.pulse, bus_a.status,
                 m_level[0], m_pulse[0], m_status[0]);
      end
    end
  endtask

  task automatic test_modes;
    int cnt [4];
    int want [4];
    want = '{0, 1, 1, 2};
    cnt  = '{0, 0, 0, 0};
    bus_a.edge_mode = 8'hE4;
    for (int t = 1; t <= 24; t++) begin
      bus_a.in = (t <= 10) ? 4'hF : 4'h0;
      @(negedge clk);
      for (int c = 0; c < 4; c++) cnt[c] += int'(bus_a.pulse[c]);
      checks++;
      if (bus_a.level !== 4'h0 && bus_a.level !== 4'hF) begin
        errors++;
        $display("FAIL modes_level e%0d got %h want uniform",
                 t, bus_a.level);
      end
      checks++;
      if ({bus_a.level, bus_a.pulse, bus_a.status,
           bus_a.any_pulse} !==
          {m_level[0], m_pulse[0], m_status[0], m_any[0]}) begin
        errors++;
        $display("FAIL modes_model e%0d got p=%h s=%h want p=%h s=%h",
                 t, bus_a.pulse, bus_a.status,
                 m_pulse[0], m_status[0]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (cnt[c] != want[c]) begin
        errors++;
        $display("FAIL modes_count ch%0d got %0d want %0d",
                 c, cnt[c], want[c]);
      end
    end
  endtask

  task automatic test_clear_collision;
    bus_a.edge_mode = 8'h30;
    bus_a.in[2] = 1'b1;
    repeat (9) @(negedge clk);
    checks++;
    if (bus_a.status[2] !== 1'b1) begin
      errors++;
      $display("FAIL clr_setup got s2=%b want 1", bus_a.status[2]);
    end
    for (int t = 1; t <= 8; t++) begin
      bus_a.in[2] = 1'b0;
      bus_a.clear = (t == 7 || t == 8) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      if (t == 6) begin
        checks++;
        if (bus_a.pulse[2] !== 1'b1) begin
          errors++;
          $display("FAIL clr_pulse got p2=%b want 1", bus_a.pulse[2]);
        end
      end
      if (t == 7) begin
        checks++;
        if (bus_a.status[2] !== 1'b1) begin
          errors++;
          $display("FAIL clr_collide got s2=%b want 1", bus_a.status[2]);
        end
      end
      if (t == 8) begin
        checks++;
        if (bus_a.status[2] !== 1'b0) begin
          errors++;
          $display("FAIL clr_alone got s2=%b want 0", bus_a.status[2]);
        end
      end
    end
    bus_a.clear = 4'h0;
  endtask

  task automatic test_reset_mid;
    logic [3:0] el, ep;
    bus_a.edge_mode = 8'h04;
    bus_a.in = 4'b0011;
    repeat (10) @(negedge clk);
    bus_a.in = 4'b0001;
    repeat (8) @(negedge clk);
    for (int t = 1; t <= 4; t++) begin
      bus_a.in = 4'b0011;
      @(negedge clk);
    end
    checks++;
    if (bus_a.status[1] !== 1'b1 || bus_a.level[0] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre got s1=%b l0=%b want 1 1",
               bus_a.status[1], bus_a.level[0]);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus_a.level, bus_a.pulse, bus_a.status,
         bus_a.any_pulse} !== 13'h0) begin
      errors++;
      $display("FAIL midrst_async got l=%h s=%h want 0 0",
               bus_a.level, bus_a.status);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      @(negedge clk);
      el = (t >= 6) ? 4'b0011 : 4'b0000;
      ep = (t == 6) ? 4'b0010 : 4'b0000;
      checks++;
      if ({bus_a.level, bus_a.pulse} !== {el, ep}) begin
        errors++;
        $display("FAIL midrst_restart e%0d got l=%h p=%h want l=%h p=%h",
                 t, bus_a.level, bus_a.pulse, el, ep);
      end
    end
  endtask

  task automatic test_random;
    for (int t = 0; t < 400; t++) begin
      if (t % 50 == 0) begin
        bus_a.edge_mode = 8'($urandom);
        bus_b.edge_mode = 8'($urandom);
      end
      bus_a.in ^= 4'($urandom) & 4'($urandom) & 4'($urandom);
      bus_b.in ^= 4'($urandom) & 4'($urandom);
      bus_a.clear = 4'($urandom) & 4'($urandom) & 4'($urandom);
      bus_b.clear = 4'($urandom) & 4'($urandom) & 4'($urandom);
      @(negedge clk);
      checks++;
      if ({bus_a.level, bus_a.pulse, bus_a.status,
           bus_a.any_pulse} !==
          {m_level[0], m_pulse[0], m_status[0], m_any[0]}) begin
        errors++;
        $display("FAIL rand_a c%0d got l=%h p=%h s=%h a=%b want l=%h p=%h s=%h a=%b",
                 t, bus_a.level, bus_a.pulse, bus_a.status,
                 bus_a.any_pulse, m_level[0], m_pulse[0],
                 m_status[0], m_any[0]);
      end
      checks++;
      if ({bus_b.level, bus_b.pulse, bus_b.status,
           bus_b.any_pulse} !==
          {m_level[1], m_pulse[1], m_status[1], m_any[1]}) begin
        errors++;
        $display("FAIL rand_b c%0d got l=%h p=%h s=%h a=%b want l=%h p=%h s=%h a=%b",
                 t, bus_b.level, bus_b.pulse, bus_b.status,
                 bus_b.any_pulse, m_level[1], m_pulse[1],
                 m_status[1], m_any[1]);
      end
    end
    bus_a.clear = 4'h0;
    bus_b.clear = 4'h0;
  endtask

  task automatic test_fc1;
    logic v [32];
    logic lv, prev_lv, ep;
    int   np, want_np;
    bus_b.in = 4'h0;
    bus_b.edge_mode = 8'h03;
    repeat (8) @(negedge clk);
    for (int k = 1; k < 32; k++) v[k] = (k <= 20) ? 1'(((k - 1) / 2 + 1) % 2) : 1'b0;
    v[0] = 1'b0;
    prev_lv = 1'b0;
    np = 0;
    want_np = 0;
    for (int t = 1; t <= 28; t++) begin
      bus_b.in[0] = v[t];
      @(negedge clk);
      lv = (t >= 4) ? v[t-3] : 1'b0;
      ep = (lv != prev_lv);
      prev_lv = lv;
      want_np += int'(ep);
      np += int'(bus_b.pulse[0]);
      checks++;
      if ({bus_b.level[0], bus_b.pulse[0]} !== {lv, ep}) begin
        errors++;
        $display("FAIL fc1 e%0d got l=%b p=%b want l=%b p=%b",
                 t, bus_b.level[0], bus_b.pulse[0], lv, ep);
      end
      checks++;
      if ({bus_b.level, bus_b.pulse, bus_b.status,
           bus_b.any_pulse} !==
          {m_level[1], m_pulse[1], m_status[1], m_any[1]}) begin
        errors++;
        $display("FAIL fc1_model e%0d got l=%h p=%h want l=%h p=%h",
                 t, bus_b.level, bus_b.pulse,
                 m_level[1], m_pulse[1]);
      end
    end
    checks++;
    if (np != want_np) begin
      errors++;
      $display("FAIL fc1_count got %0d want %0d", np, want_np);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    bus_a.in = '0;
    bus_a.edge_mode = '0;
    bus_a.clear = '0;
    bus_b.in = '0;
    bus_b.edge_mode = '0;
    bus_b.clear = '0;
    test_reset();
    test_glitch();
    test_modes();
    test_clear_collision();
    test_reset_mid();
    test_random();
    test_fc1();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
